// File: rtl/fp8_dot_sequencer.sv
// Dot-product sequencer: feeds one shared FP8 E4M3 FMA one operand pair at a time
// and returns the final accumulator over a valid/ready result port.
module fp8_dot_sequencer #(
  parameter int unsigned LEN_W   = 8,
  parameter int unsigned FMA_LAT = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       acc_init,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic [7:0]       fma_a,
  output logic [7:0]       fma_b,
  output logic [7:0]       fma_c,
  output logic             fma_issue,
  input  logic [7:0]       fma_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [LEN_W-1:0] elem_cnt
);

  localparam logic [3:0] LAT_INIT = 4'(FMA_LAT);

  typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_EXEC, S_DONE} state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_elem_cnt;
  logic [7:0]       r_acc;
  logic [7:0]       r_fma_a;
  logic [7:0]       r_fma_b;
  logic [7:0]       r_fma_c;
  logic [7:0]       r_out_data;
  logic [3:0]       r_lat;
  logic             r_issue;

  logic             w_start_acc;
  logic             w_hs;
  logic             w_cap;
  logic [LEN_W-1:0] w_cnt_inc;

  assign w_start_acc = (r_state == S_IDLE) && start;
  assign w_hs        = (r_state == S_ACCEPT) && in_valid;
  assign w_cap       = (r_state == S_EXEC) && (r_lat == 4'd0);
  // elem_cnt < len always holds inside a job, so the increment cannot overflow LEN_W
  assign w_cnt_inc   = r_elem_cnt + LEN_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = (len == '0) ? S_DONE : S_ACCEPT;
      S_ACCEPT: if (in_valid) w_next = S_EXEC;
      S_EXEC:   if (r_lat == 4'd0) w_next = (w_cnt_inc == r_len) ? S_DONE : S_ACCEPT;
      S_DONE:   if (out_ready) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    in_ready  = (r_state == S_ACCEPT);
    out_valid = (r_state == S_DONE);
    fma_issue = r_issue;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_elem_cnt <= '0;
      r_acc      <= '0;
      r_fma_a    <= '0;
      r_fma_b    <= '0;
      r_fma_c    <= '0;
      r_out_data <= '0;
      r_lat      <= '0;
      r_issue    <= 1'b0;
    end else begin
      r_issue <= w_hs;
      if (w_start_acc) begin
        r_len      <= len;
        r_acc      <= acc_init;
        r_elem_cnt <= '0;
        if (len == '0) r_out_data <= acc_init;
      end
      if (w_hs) begin
        r_fma_a <= in_a;
        r_fma_b <= in_b;
        r_fma_c <= r_acc;
        r_lat   <= LAT_INIT;
      end else if ((r_state == S_EXEC) && (r_lat != 4'd0)) begin
        r_lat <= r_lat - 4'd1;
      end
      if (w_cap) begin
        r_acc      <= fma_result;
        r_elem_cnt <= w_cnt_inc;
        if (w_cnt_inc == r_len) r_out_data <= fma_result;
      end
    end
  end

  assign fma_a    = r_fma_a;
  assign fma_b    = r_fma_b;
  assign fma_c    = r_fma_c;
  assign out_data = r_out_data;
  assign elem_cnt = r_elem_cnt;

endmodule

// File: tb/tb_fp8_dot_sequencer.sv
// Bench: a combinational-FMA instance driven from a vector table, and a
// latency-3 instance with a counting stub for pipelining, backpressure and reset cases.
module tb_fp8_dot_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start0 = 1'b0, in_valid0 = 1'b0, ordy0 = 1'b0, fma_mode0 = 1'b0;
  logic [7:0] len0 = '0, acc0 = '0, in_a0 = '0, in_b0 = '0;
  logic       busy0, in_ready0, iss0, ov0;
  logic [7:0] fa0, fb0, fc0, fr0, od0, ec0;

  logic       start1 = 1'b0, in_valid1 = 1'b0, ordy1 = 1'b0;
  logic [7:0] len1 = '0, acc1 = '0, in_a1 = '0, in_b1 = '0;
  logic       busy1, in_ready1, iss1, ov1;
  logic [7:0] fa1, fb1, fc1, fr1, od1, ec1;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;
  int issues0 = 0;
  int icnt1 = 0;
  int base1 = 0;

  fp8_dot_sequencer #(.LEN_W(8), .FMA_LAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .len(len0), .acc_init(acc0), .busy(busy0),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_a(in_a0), .in_b(in_b0),
    .fma_a(fa0), .fma_b(fb0), .fma_c(fc0), .fma_issue(iss0), .fma_result(fr0),
    .out_valid(ov0), .out_ready(ordy0), .out_data(od0), .elem_cnt(ec0)
  );

  fp8_dot_sequencer #(.LEN_W(8), .FMA_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .len(len1), .acc_init(acc1), .busy(busy1),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
    .fma_a(fa1), .fma_b(fb1), .fma_c(fc1), .fma_issue(iss1), .fma_result(fr1),
    .out_valid(ov1), .out_ready(ordy1), .out_data(od1), .elem_cnt(ec1)
  );

  function automatic real fp8_val(input logic [7:0] x);
    real v;
    int  ex;
    v  = (x[6:3] == 4'd0) ? 0.0 : 1.0;
    v  = v + real'(x[2:0]) / 8.0;
    ex = (x[6:3] == 4'd0) ? -6 : int'(x[6:3]) - 7;
    for (int i = 0; i < ex; i++) v = v * 2.0;
    for (int i = ex; i < 0; i++) v = v / 2.0;
    return x[7] ? -v : v;
  endfunction

  function automatic logic [7:0] fp8_enc(input real r);
    real        mag, d, bd;
    logic [7:0] best, c;
    mag  = (r < 0.0) ? -r : r;
    best = 8'h00;
    bd   = 1.0e30;
    for (int i = 0; i < 127; i++) begin
      c = 8'(i);
      d = fp8_val(c) - mag;
      if (d < 0.0) d = -d;
      if (d < bd) begin
        bd   = d;
        best = c;
      end
    end
    if ((r < 0.0) && (best != 8'h00)) best[7] = 1'b1;
    return best;
  endfunction

  function automatic logic [7:0] fp8_fma(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    return fp8_enc(fp8_val(a) * fp8_val(b) + fp8_val(c));
  endfunction

  assign fr0 = fma_mode0 ? 8'hFF : fp8_fma(fa0, fb0, fc0);
  // latency-3 stub: result is the number of operations issued since base1
  assign fr1 = 8'(icnt1 - base1);

  always @(posedge clk) begin
    if (iss0) issues0 <= issues0 + 1;
    if (iss1) icnt1 <= icnt1 + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]      len;
    logic [7:0]      acc;
    logic [0:3][7:0] a;
    logic [0:3][7:0] b;
    logic            sat;
    logic            gaps;
    logic [7:0]      exp_out;
  } vec_t;

  vec_t       vecs[6];
  vec_t       cur;
  int         jj;
  logic [7:0] run_acc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic tick0();
    tick();
    if (iss0) begin
      chk("fma_c0_at_issue", 64'(fc0), 64'(run_acc));
      if (jj < 4) run_acc = cur.sat ? 8'hFF : fp8_fma(cur.a[jj], cur.b[jj], run_acc);
      jj++;
    end
  endtask

  task automatic run_job0(input vec_t v);
    int k, bud, lat, base0;
    logic hs;
    cur     = v;
    jj      = 0;
    run_acc = v.acc;
    base0   = issues0;
    fma_mode0 = v.sat;
    start0 = 1'b1; len0 = v.len; acc0 = v.acc;
    tick0();
    start0 = 1'b0;
    lat = 1; k = 0; bud = 0;
    while (k < int'(v.len) && bud < 300) begin
      in_valid0 = v.gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      in_a0 = v.a[k];
      in_b0 = v.b[k];
      hs = in_valid0 && in_ready0;
      tick0();
      bud++; lat++;
      if (hs) k++;
    end
    in_valid0 = 1'b0;
    while (!ov0 && bud < 300) begin
      tick0();
      bud++; lat++;
    end
    chk("job0_out_valid", 64'(ov0), 64'd1);
    if (v.len == 8'd0) chk("len0_latency", 64'(lat), 64'd1);
    chk("job0_out_data", 64'(od0), 64'(v.exp_out));
    chk("job0_elem_cnt", 64'(ec0), 64'(v.len));
    chk("job0_issues", 64'(issues0 - base0), 64'(v.len));
    ordy0 = 1'b1;
    tick0();
    ordy0 = 1'b0;
    chk("job0_idle_after", 64'({busy0, ov0}), 64'd0);
  endtask

  task automatic run_job1(input logic [7:0] l, input logic [7:0] a, input logic [7:0] exp_out);
    int bud;
    base1 = icnt1;
    start1 = 1'b1; len1 = l; acc1 = a;
    in_valid1 = 1'b1;
    tick();
    start1 = 1'b0;
    bud = 0;
    while (!ov1 && bud < 200) begin
      if (iss1 && (icnt1 == base1)) chk("job1_first_fma_c", 64'(fc1), 64'(a));
      tick();
      bud++;
    end
    in_valid1 = 1'b0;
    chk("job1_out_valid", 64'(ov1), 64'd1);
    chk("job1_out_data", 64'(od1), 64'(exp_out));
    chk("job1_elem_cnt", 64'(ec1), 64'(l));
    ordy1 = 1'b1;
    tick();
    ordy1 = 1'b0;
  endtask

  initial begin
    int   bud, nhs, ni, last_hs;
    logic hs;

    vecs[0] = '{len:8'd2, acc:8'h00, a:{8'h38, 8'h40, 8'h00, 8'h00}, b:{8'h38, 8'h38, 8'h00, 8'h00},
                sat:1'b0, gaps:1'b0, exp_out:8'h44};
    vecs[1] = '{len:8'd0, acc:8'h50, a:'0, b:'0, sat:1'b0, gaps:1'b0, exp_out:8'h50};
    vecs[2] = '{len:8'd1, acc:8'h38, a:{8'h40, 8'h00, 8'h00, 8'h00}, b:{8'h40, 8'h00, 8'h00, 8'h00},
                sat:1'b0, gaps:1'b0, exp_out:8'h4A};
    vecs[3] = '{len:8'd3, acc:8'h00, a:{8'h38, 8'h38, 8'h38, 8'h00}, b:{8'h38, 8'h38, 8'h38, 8'h00},
                sat:1'b0, gaps:1'b1, exp_out:8'h44};
    vecs[4] = '{len:8'd1, acc:8'h40, a:{8'hB8, 8'h00, 8'h00, 8'h00}, b:{8'h38, 8'h00, 8'h00, 8'h00},
                sat:1'b0, gaps:1'b0, exp_out:8'h38};
    vecs[5] = '{len:8'd2, acc:8'h00, a:{8'h38, 8'h38, 8'h00, 8'h00}, b:{8'h38, 8'h38, 8'h00, 8'h00},
                sat:1'b1, gaps:1'b1, exp_out:8'hFF};

    #12;
    chk("reset_dut0", 64'({busy0, in_ready0, iss0, ov0, fa0, fb0, fc0, od0, ec0}), 64'd0);
    chk("reset_dut1", 64'({busy1, in_ready1, iss1, ov1, fa1, fb1, fc1, od1, ec1}), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 6; i++) run_job0(vecs[i]);

    // pipelined FMA, in_valid held high
    base1 = icnt1;
    in_valid1 = 1'b1; in_a1 = 8'h21; in_b1 = 8'h32;
    start1 = 1'b1; len1 = 8'd4; acc1 = 8'h00;
    tick();
    start1 = 1'b0;
    nhs = 0; ni = 0; bud = 0; last_hs = 0;
    while (!ov1 && bud < 100) begin
      hs = in_valid1 && in_ready1;
      if (hs) begin
        if (nhs > 0) chk("in_ready_spacing", 64'(cyc - last_hs), 64'd5);
        last_hs = cyc;
        nhs++;
      end
      if (iss1) begin
        chk("fma_c1_prev_capture", 64'(fc1), 64'(icnt1 - base1));
        ni++;
      end
      tick();
      bud++;
    end
    in_valid1 = 1'b0;
    chk("pipe_out_valid", 64'(ov1), 64'd1);
    chk("pipe_handshakes", 64'(nhs), 64'd4);
    chk("pipe_issues", 64'(ni), 64'd4);
    chk("pipe_out_data", 64'(od1), 64'd4);
    chk("pipe_elem_cnt", 64'(ec1), 64'd4);

    // result held under backpressure; start during busy ignored
    len1 = 8'd7; acc1 = 8'h11;
    for (int i = 0; i < 10; i++) begin
      start1 = (i == 3);
      chk("hold_result", 64'({ov1, od1}), 64'({1'b1, 8'h04}));
      tick();
    end
    start1 = 1'b0;
    ordy1 = 1'b1; start1 = 1'b1;
    tick();
    ordy1 = 1'b0; start1 = 1'b0;
    chk("start_at_handshake_ignored", 64'({busy1, ov1, in_ready1}), 64'd0);
    run_job1(8'd1, 8'h20, 8'h01);

    // reset during EXEC of element 2 of 5
    base1 = icnt1;
    in_valid1 = 1'b1; in_a1 = 8'h5A; in_b1 = 8'h3C;
    start1 = 1'b1; len1 = 8'd5; acc1 = 8'h00;
    tick();
    start1 = 1'b0;
    bud = 0;
    while (!(iss1 && (icnt1 - base1 == 2)) && bud < 100) begin
      tick();
      bud++;
    end
    chk("reach_elem2_exec", 64'(bud < 100), 64'd1);
    tick();
    chk("elem_cnt_before_reset", 64'(ec1), 64'd2);
    #2 rst_n = 1'b0;
    #1 chk("reset_mid_job", 64'({busy1, in_ready1, iss1, ov1, fa1, fb1, fc1, od1, ec1}), 64'd0);
    in_valid1 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("idle_after_reset", 64'({busy1, ov1, in_ready1}), 64'd0);
    run_job1(8'd2, 8'h00, 8'h02);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
